// File: rtl/cv32e40s_pkg.sv
// Shared types for the CSR integrity controller: scan FSM states and timer width.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    ICTRL_COUNT,
    ICTRL_CHECK,
    ICTRL_LOCKED
  } csr_ictrl_state_e;

  // Wide enough for the largest supported scan period (255).
  localparam int ICTRL_TIMER_W = 8;

endpackage

// File: rtl/cv32e40s_csr_ictrl_arb.sv
// Write arbiter for the hardened CSR bank: core writes win over refresh writes,
// the winner is registered and issued one cycle later as a one-hot enable.
module cv32e40s_csr_ictrl_arb #(
  parameter int NUM_CSR = 8,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = $clog2(NUM_CSR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_wr_en,
  input  logic [IDX_W-1:0]   sw_wr_idx,
  input  logic [WIDTH-1:0]   sw_wr_data,
  input  logic               rfr_req,
  input  logic [IDX_W-1:0]   rfr_idx,
  input  logic [WIDTH-1:0]   rfr_data,
  output logic               rfr_gnt,
  output logic [NUM_CSR-1:0] csr_wr_en,
  output logic [WIDTH-1:0]   csr_wr_data
);

  logic               vld_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic [WIDTH-1:0]   data_p0;
  logic [NUM_CSR-1:0] wr_en_p1;
  logic [WIDTH-1:0]   data_p1;

  // Indices outside the bank match no bit, so they are granted but write nothing.
  function automatic logic [NUM_CSR-1:0] decode_onehot(input logic vld,
                                                       input logic [IDX_W-1:0] idx);
    logic [NUM_CSR-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      oh[i] = vld && (idx == IDX_W'(i));
    end
    return oh;
  endfunction

  // Stage p0: combinational priority select
  always_comb begin
    rfr_gnt = rfr_req & ~sw_wr_en;
    vld_p0  = sw_wr_en | rfr_req;
    idx_p0  = sw_wr_en ? sw_wr_idx  : rfr_idx;
    data_p0 = sw_wr_en ? sw_wr_data : rfr_data;
  end

  // Stage p1: registered issue towards the bank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_p1 <= '0;
      data_p1  <= '0;
    end else begin
      wr_en_p1 <= decode_onehot(vld_p0, idx_p0);
      if (vld_p0) begin
        data_p1 <= data_p0;
      end
    end
  end

  assign csr_wr_en   = wr_en_p1;
  assign csr_wr_data = data_p1;

endmodule

// File: rtl/cv32e40s_csr_integrity_ctrl.sv
// Integrity controller for a bank of shadow-copy CSRs: write arbitration,
// periodic round-robin rd_error scan with first-failure capture, and major alert.
module cv32e40s_csr_integrity_ctrl
  import cv32e40s_pkg::*;
#(
  parameter int NUM_CSR     = 8,
  parameter int WIDTH       = 32,
  parameter int SCAN_PERIOD = 16,
  parameter int IDX_W       = $clog2(NUM_CSR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_wr_en_i,
  input  logic [IDX_W-1:0]   sw_wr_idx_i,
  input  logic [WIDTH-1:0]   sw_wr_data_i,
  input  logic               rfr_req_i,
  input  logic [IDX_W-1:0]   rfr_idx_i,
  input  logic [WIDTH-1:0]   rfr_data_i,
  output logic               rfr_gnt_o,
  output logic [NUM_CSR-1:0] csr_wr_en_o,
  output logic [WIDTH-1:0]   csr_wr_data_o,
  input  logic [NUM_CSR-1:0] csr_rd_error_i,
  output logic               err_valid_o,
  output logic [IDX_W-1:0]   err_idx_o,
  input  logic               err_clr_i,
  output logic               alert_major_o
);

  localparam logic [ICTRL_TIMER_W-1:0] TIMER_LAST = ICTRL_TIMER_W'(SCAN_PERIOD - 1);

  csr_ictrl_state_e           state_q, state_d;
  logic [ICTRL_TIMER_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic [IDX_W-1:0]           err_idx_q, err_idx_d;
  logic                       alert_q;
  logic [NUM_CSR-1:0]         csr_wr_en;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_CSR - 1)) ? '0 : p + 1'b1;
  endfunction

  cv32e40s_csr_ictrl_arb #(
    .NUM_CSR (NUM_CSR),
    .WIDTH   (WIDTH),
    .IDX_W   (IDX_W)
  ) arb_i (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_wr_en    (sw_wr_en_i),
    .sw_wr_idx   (sw_wr_idx_i),
    .sw_wr_data  (sw_wr_data_i),
    .rfr_req     (rfr_req_i),
    .rfr_idx     (rfr_idx_i),
    .rfr_data    (rfr_data_i),
    .rfr_gnt     (rfr_gnt_o),
    .csr_wr_en   (csr_wr_en),
    .csr_wr_data (csr_wr_data_o)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ptr_d     = ptr_q;
    err_idx_d = err_idx_q;
    case (state_q)
      ICTRL_COUNT: begin
        if (timer_q == TIMER_LAST) begin
          state_d = ICTRL_CHECK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ICTRL_CHECK: begin
        // A CSR being rewritten this cycle is mid-repair and counts as passing.
        if (csr_rd_error_i[ptr_q] && !csr_wr_en[ptr_q]) begin
          state_d   = ICTRL_LOCKED;
          err_idx_d = ptr_q;
        end else begin
          state_d = ICTRL_COUNT;
          ptr_d   = next_ptr(ptr_q);
        end
      end
      ICTRL_LOCKED: begin
        if (err_clr_i) begin
          state_d = ICTRL_COUNT;
          ptr_d   = next_ptr(err_idx_q);
        end
      end
      default: state_d = ICTRL_COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ICTRL_COUNT;
      timer_q   <= '0;
      ptr_q     <= '0;
      err_idx_q <= '0;
      alert_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
      err_idx_q <= err_idx_d;
      alert_q   <= |csr_rd_error_i;
    end
  end

  // The registered OR of all flags alerts within one cycle, ahead of the scan.
  assign csr_wr_en_o   = csr_wr_en;
  assign err_valid_o   = (state_q == ICTRL_LOCKED);
  assign err_idx_o     = err_idx_q;
  assign alert_major_o = alert_q | (state_q == ICTRL_LOCKED);

endmodule
